// File: rtl/calcn_pkg.sv
// calcn_pkg: shared definitions for the calcn multi-port calculator.
// Holds the command codes, the response codes and the per-port capture
// FSM state type. Imported by calcn and calcn_alu.
package calcn_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;
  localparam logic [3:0] CMD_ROL = 4'd8;
  localparam logic [3:0] CMD_ROR = 4'd9;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_PEND
  } port_state_t;

endpackage

// File: rtl/calcn_alu.sv
// calcn_alu: combinational unsigned ALU shared by all calcn ports.
// Ports:
//   cmd    in  4       command code of the granted request
//   op1    in  DATA_W  first operand
//   op2    in  DATA_W  second operand (shift/rotate amount in low SH_W bits)
//   result out DATA_W  result, zero on any error
//   resp   out 2       RESP_OK or RESP_ERR
// Build option: CALCN_ROTATE_EN adds rotate-left/right (cmds 8/9); without it
// those codes fall into the invalid-command path.
module calcn_alu
  import calcn_pkg::*;
#(
  parameter int  DATA_W = 32,
  localparam int SH_W   = $clog2(DATA_W)
) (
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        resp
);

  logic [DATA_W:0]   sum_ext;
  logic [SH_W-1:0]   sh;

  assign sum_ext = {1'b0, op1} + {1'b0, op2};
  assign sh      = op2[SH_W-1:0];

  always_comb begin
    result = '0;
    resp   = RESP_ERR;
    case (cmd)
      CMD_ADD: begin
        if (!sum_ext[DATA_W]) begin
          result = sum_ext[DATA_W-1:0];
          resp   = RESP_OK;
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          result = op1 - op2;
          resp   = RESP_OK;
        end
      end
      CMD_SHL: begin
        result = op1 << sh;
        resp   = RESP_OK;
      end
      CMD_SHR: begin
        result = op1 >> sh;
        resp   = RESP_OK;
      end
`ifdef CALCN_ROTATE_EN
      // A shift by the full width yields zero, so sh == 0 returns op1.
      CMD_ROL: begin
        result = (op1 << sh) | (op1 >> (DATA_W - int'(sh)));
        resp   = RESP_OK;
      end
      CMD_ROR: begin
        result = (op1 >> sh) | (op1 << (DATA_W - int'(sh)));
        resp   = RESP_OK;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/calcn.sv
// calcn: parametrised multi-port calculator. Each port captures a two-cycle
// command (cmd + op1, then op2), a round-robin arbiter picks one pending port
// per cycle for the shared ALU, and the granted port gets a one-cycle
// registered response.
// Ports:
//   c_clk        in  1                 clock, rising edge
//   reset        in  1                 synchronous active-high reset
//   req_cmd_in   in  NUM_PORTS*4       per-port command, port i at [4i+3:4i]
//   req_data_in  in  NUM_PORTS*DATA_W  per-port operand
//   out_data     out NUM_PORTS*DATA_W  per-port result (one cycle)
//   out_resp     out NUM_PORTS*2       per-port response 0 none/1 ok/2 err
//   out_busy     out NUM_PORTS         port cannot accept a command
// Build option: CALCN_ROTATE_EN (see calcn_alu) enables rotate commands.
//
// Per-port FSM:
//   state   | meaning
//   ST_IDLE | free; nonzero cmd latches cmd and op1
//   ST_OP2  | op2 taken from req_data_in unconditionally, cmd ignored
//   ST_PEND | waiting for arbiter grant; returns to ST_IDLE on grant edge
module calcn
  import calcn_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS-1:0]        out_busy
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] pend;
  logic [3:0]           cmd_arr [NUM_PORTS];
  logic [DATA_W-1:0]    op1_arr [NUM_PORTS];
  logic [DATA_W-1:0]    op2_arr [NUM_PORTS];

  logic [NUM_PORTS-1:0] gnt_vec;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic [PTR_W-1:0]     rr;

  logic [DATA_W-1:0]    alu_result;
  logic [1:0]           alu_resp;

  logic [NUM_PORTS*DATA_W-1:0] data_q;
  logic [NUM_PORTS*2-1:0]      resp_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    port_state_t       state, state_nxt;
    logic [3:0]        cmd_i;
    logic [DATA_W-1:0] data_i;
    logic [3:0]        cmd_q;
    logic [DATA_W-1:0] op1_q, op2_q;

    assign cmd_i  = req_cmd_in[4*i +: 4];
    assign data_i = req_data_in[DATA_W*i +: DATA_W];

    always_ff @(posedge c_clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      case (state)
        ST_IDLE: if (cmd_i != CMD_NOP) state_nxt = ST_OP2;
        ST_OP2:  state_nxt = ST_PEND;
        ST_PEND: if (gnt_vec[i]) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge c_clk) begin
      if (reset) begin
        cmd_q <= CMD_NOP;
        op1_q <= '0;
        op2_q <= '0;
      end else begin
        if (state == ST_IDLE && cmd_i != CMD_NOP) begin
          cmd_q <= cmd_i;
          op1_q <= data_i;
        end
        if (state == ST_OP2) op2_q <= data_i;
      end
    end

    assign pend[i]     = (state == ST_PEND);
    assign out_busy[i] = (state != ST_IDLE);
    assign cmd_arr[i]  = cmd_q;
    assign op1_arr[i]  = op1_q;
    assign op2_arr[i]  = op2_q;
  end

  // Round-robin: first pending port at or after rr, wrapping.
  always_comb begin
    int               s;
    logic [PTR_W-1:0] idx;
    gnt_vec   = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    s         = 0;
    idx       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      s = int'(rr) + k;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      idx = PTR_W'(s);
      if (!gnt_valid && pend[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
    if (gnt_valid) gnt_vec[gnt_idx] = 1'b1;
  end

  calcn_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd    (cmd_arr[gnt_idx]),
    .op1    (op1_arr[gnt_idx]),
    .op2    (op2_arr[gnt_idx]),
    .result (alu_result),
    .resp   (alu_resp)
  );

  // Response registers clear every cycle unless reloaded by a grant.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      rr     <= '0;
      data_q <= '0;
      resp_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        data_q[DATA_W*i +: DATA_W] <= gnt_vec[i] ? alu_result : '0;
        resp_q[2*i +: 2]           <= gnt_vec[i] ? alu_resp : RESP_NONE;
      end
      if (gnt_valid)
        rr <= (gnt_idx == PTR_W'(NUM_PORTS-1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  assign out_data = data_q;
  assign out_resp = resp_q;

endmodule

// File: tb/tb_calcn.sv
// tb_calcn: directed plus randomized bench for calcn with a transaction-level
// reference model (per-port phase, round-robin pick, arithmetic ALU).
module tb_calcn;
  localparam int NP = 4;
  localparam int DW = 32;

  logic                c_clk = 1'b0;
  logic                reset = 1'b1;
  logic [NP*4-1:0]     req_cmd_in;
  logic [NP*DW-1:0]    req_data_in;
  logic [NP*DW-1:0]    out_data;
  logic [NP*2-1:0]     out_resp;
  logic [NP-1:0]       out_busy;

  logic [3:0]          cmd_v  [NP];
  logic [DW-1:0]       data_v [NP];

  int n_cmp = 0;
  int n_bad = 0;

  calcn #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_data    (out_data),
    .out_resp    (out_resp),
    .out_busy    (out_busy)
  );

  always #5 c_clk = ~c_clk;

  always_comb begin
    req_cmd_in  = '0;
    req_data_in = '0;
    for (int i = 0; i < NP; i++) begin
      req_cmd_in[4*i +: 4]    = cmd_v[i];
      req_data_in[DW*i +: DW] = data_v[i];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU in 64-bit arithmetic.
  function automatic void alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic [1:0] r);
    longint unsigned A, B;
    int s;
    A = 64'(a);
    B = 64'(b);
    s = int'(b % 32);
    d = '0;
    r = 2'd2;
    case (c)
      4'd1: if (A + B <= 64'hFFFF_FFFF) begin d = 32'(A + B); r = 2'd1; end
      4'd2: if (B <= A) begin d = 32'(A - B); r = 2'd1; end
      4'd5: begin d = 32'(A << s); r = 2'd1; end
      4'd6: begin d = 32'(A >> s); r = 2'd1; end
`ifdef CALCN_ROTATE_EN
      4'd8: begin d = 32'((A << s) | (A >> (32 - s))); r = 2'd1; end
      4'd9: begin d = 32'((A >> s) | (A << (32 - s))); r = 2'd1; end
`endif
      default: ;
    endcase
  endfunction

  // Model: ph 0 free, 1 awaiting op2, 2 waiting for service.
  int          ph [NP];
  logic [3:0]  mc [NP];
  logic [31:0] m1 [NP];
  logic [31:0] m2 [NP];
  logic [31:0] ed [NP];
  logic [1:0]  er [NP];
  int          rr_m = 0;
  bit          started = 1'b0;

  always @(posedge c_clk) begin : model
    int g;
    logic [31:0] d;
    logic [1:0]  r;
    if (reset) begin
      started = 1'b1;
      rr_m = 0;
      for (int i = 0; i < NP; i++) begin
        ph[i] = 0; ed[i] = '0; er[i] = '0;
      end
    end else if (started) begin
      g = -1;
      for (int k = 0; k < NP; k++)
        if (g < 0 && ph[(rr_m + k) % NP] == 2) g = (rr_m + k) % NP;
      for (int i = 0; i < NP; i++) begin
        ed[i] = '0; er[i] = '0;
      end
      if (g >= 0) begin
        alu_ref(mc[g], m1[g], m2[g], d, r);
        ed[g] = d; er[g] = r; ph[g] = 0;
        rr_m = (g + 1) % NP;
      end
      for (int i = 0; i < NP; i++) begin
        if (i != g) begin
          if (ph[i] == 1) begin
            m2[i] = data_v[i]; ph[i] = 2;
          end else if (ph[i] == 0 && cmd_v[i] != 4'd0) begin
            mc[i] = cmd_v[i]; m1[i] = data_v[i]; ph[i] = 1;
          end
        end
      end
    end
  end

  always @(negedge c_clk) begin
    if (started) begin
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("cyc_data[%0d]", i), out_data[DW*i +: DW], ed[i]);
        chk($sformatf("cyc_resp[%0d]", i), out_resp[2*i +: 2], er[i]);
        chk($sformatf("cyc_busy[%0d]", i), out_busy[i], ph[i] != 0);
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NP; i++) begin
      cmd_v[i] = '0; data_v[i] = '0;
    end
  endtask

  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    cmd_v[p] = c; data_v[p] = a;
    tick();
    cmd_v[p] = '0; data_v[p] = b;
    tick();
    data_v[p] = '0;
  endtask

  task automatic run1(input string nm, input int p, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] xr, input logic [31:0] xd);
    issue(p, c, a, b);
    tick();
    chk({nm, "_resp"}, out_resp[2*p +: 2], xr);
    chk({nm, "_data"}, out_data[DW*p +: DW], xd);
    chk({nm, "_busy"}, out_busy[p], 1'b0);
  endtask

  initial begin
    logic [3:0] ctab [10];
    logic [3:0] be;
    ctab = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd8, 4'd9, 4'd15, 4'd7};
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_data", out_data, '0);
    chk("rst_resp", out_resp, '0);
    chk("rst_busy", out_busy, '0);
    reset = 1'b0;

    run1("add0", 0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
    tick();
    chk("add0_hold", out_resp[1:0], 2'd0);

    run1("ovf",   1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0);
    run1("undf",  1, 4'd2, 32'h1, 32'hF, 2'd2, 32'h0);
    run1("sub_eq",1, 4'd2, 32'h5, 32'h5, 2'd1, 32'h0);
    run1("shl31", 2, 4'd5, 32'h1, 32'd31, 2'd1, 32'h8000_0000);
    run1("shr21", 2, 4'd6, 32'h8000_0000, 32'h21, 2'd1, 32'h4000_0000);
    run1("cmd3",  2, 4'd3, 32'h1234, 32'h1, 2'd2, 32'h0);
    run1("cmd4",  2, 4'd4, 32'h1234, 32'h1, 2'd2, 32'h0);
`ifdef CALCN_ROTATE_EN
    run1("rol",   2, 4'd8, 32'h8000_0001, 32'h1, 2'd1, 32'h0000_0003);
    run1("ror",   2, 4'd9, 32'h8000_0001, 32'h1, 2'd1, 32'hC000_0000);
`else
    run1("cmd8",  2, 4'd8, 32'h8000_0001, 32'h1, 2'd2, 32'h0);
    run1("cmd9",  2, 4'd9, 32'h8000_0001, 32'h1, 2'd2, 32'h0);
`endif

    // Busy drop on port 3: cmd held high through OP2 and PEND.
    cmd_v[3] = 4'd1; data_v[3] = 32'd10;
    tick();
    data_v[3] = 32'd20;
    tick();
    data_v[3] = 32'd99;
    tick();
    chk("bdrop_resp", out_resp[7:6], 2'd1);
    chk("bdrop_data", out_data[127:96], 32'd30);
    chk("bdrop_busy", out_busy[3], 1'b0);
    idle();
    run1("bdrop_next", 3, 4'd1, 32'd7, 32'd8, 2'd1, 32'd15);
    tick();
    chk("bdrop_quiet", out_resp[7:6], 2'd0);

    // Two all-port bursts; rr is at 0 after the port 3 grant.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NP; i++) begin
        cmd_v[i] = 4'd1; data_v[i] = 32'(i + 1 + 16 * b);
      end
      tick();
      for (int i = 0; i < NP; i++) begin
        cmd_v[i] = '0; data_v[i] = 32'd100;
      end
      tick();
      idle();
      for (int j = 0; j < NP; j++) begin
        tick();
        be = 4'(15 << (j + 1));
        chk($sformatf("burst%0d_resp%0d", b, j), out_resp, 8'(1 << (2 * j)));
        chk($sformatf("burst%0d_data%0d", b, j), out_data[DW*j +: DW], 32'(j + 101 + 16 * b));
        chk($sformatf("burst%0d_busy%0d", b, j), out_busy, be);
      end
    end

    // Reset while ports 0..2 are pending.
    for (int i = 0; i < 3; i++) begin
      cmd_v[i] = 4'd1; data_v[i] = 32'(i + 3);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      cmd_v[i] = '0; data_v[i] = 32'd4;
    end
    tick();
    idle();
    reset = 1'b1;
    tick();
    chk("mid_rst_resp", out_resp, '0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_busy", out_busy, '0);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("mid_rst_quiet%0d", j), out_resp, '0);
    end
    run1("post_rst", 1, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);

    // Randomized traffic, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        cmd_v[i] = ($urandom_range(0, 2) == 0) ? ctab[$urandom_range(0, 9)] : 4'd0;
        case ($urandom_range(0, 3))
          0: data_v[i] = $urandom;
          1: data_v[i] = 32'($urandom_range(0, 40));
          2: data_v[i] = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
          default: data_v[i] = $urandom;
        endcase
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle();
    reset = 1'b0;
    for (int j = 0; j < 8; j++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
